// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one uart TX port.
// A grant is held from first word to last word, or until an idle timeout.
module uart_tx_arbiter #(
   parameter int NR_REQ       = 4,
   parameter int NR_BITS      = 8,
   parameter int IDLE_TIMEOUT = 1000,
   localparam int GW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NR_REQ*NR_BITS-1:0] req_d,
   input  logic [NR_REQ-1:0]         req_dv,
   input  logic [NR_REQ-1:0]         req_last,
   output logic [NR_REQ-1:0]         req_dr,
   output logic [NR_BITS-1:0]        uart_tx_d,
   output logic                      uart_tx_dv,
   input  logic                      uart_tx_dr,
   output logic [GW-1:0]             grant_id,
   output logic                      grant_vld,
   output logic                      timeout
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_e;

   localparam bit          TO_EN  = (IDLE_TIMEOUT != 0);
   localparam logic [15:0] TO_MAX = 16'(IDLE_TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [GW-1:0]      gid_q, gid_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [NR_BITS-1:0] txd_q, txd_d;
   logic               txdv_q, txdv_d;
   logic               to_q, to_d;

   logic               xfer;
   logic [NR_BITS-1:0] word;
   logic               last;
   logic               found;
   logic [GW-1:0]      win;
   logic [GW-1:0]      idx;

   assign word = req_d[gid_q*NR_BITS +: NR_BITS];
   assign last = req_last[gid_q];
   assign xfer = |(req_dv & req_dr);

   // Round-robin search starts just after the last granted requester
   always_comb begin
      found = 1'b0;
      win   = gid_q;
      idx   = '0;
      for (int k = 1; k <= NR_REQ; k++) begin
         idx = GW'((int'(gid_q) + k) % NR_REQ);
         if (!found && req_dv[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gid_q   <= GW'(NR_REQ - 1);
         cnt_q   <= '0;
         txd_q   <= '0;
         txdv_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         txdv_q  <= txdv_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      txdv_d  = xfer;
      txd_d   = xfer ? word : txd_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (found) begin
               state_d = S_GRANT;
               gid_d   = win;
            end
         end
         S_GRANT: begin
            if (xfer) begin
               cnt_d = '0;
               if (last) state_d = S_IDLE;
            end else if (TO_EN && cnt_q == TO_MAX) begin
               state_d = S_IDLE;
               to_d    = 1'b1;
               cnt_d   = '0;
            end else if (TO_EN) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      grant_vld = (state_q == S_GRANT);
      req_dr    = '0;
      if (grant_vld && uart_tx_dr && !txdv_q)
         req_dr[gid_q] = 1'b1;
   end

   assign uart_tx_d  = txd_q;
   assign uart_tx_dv = txdv_q;
   assign grant_id   = gid_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with per-requester packet queues
// and a uart model that stays busy for busy_len clocks per word.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_d;
   logic [3:0]  req_dv;
   logic [3:0]  req_last;
   logic [3:0]  req_dr;
   logic [7:0]  uart_tx_d;
   logic        uart_tx_dv;
   logic        uart_tx_dr;
   logic [1:0]  grant_id;
   logic        grant_vld;
   logic        timeout;

   uart_tx_arbiter #(
      .NR_REQ(4),
      .NR_BITS(8),
      .IDLE_TIMEOUT(50)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_d(req_d),
      .req_dv(req_dv),
      .req_last(req_last),
      .req_dr(req_dr),
      .uart_tx_d(uart_tx_d),
      .uart_tx_dv(uart_tx_dv),
      .uart_tx_dr(uart_tx_dr),
      .grant_id(grant_id),
      .grant_vld(grant_vld),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          busy_len = 3;
   int          busy_cnt = 0;
   int          last_strobe_cyc = 0;
   int          hs_cnt[4];
   logic        hs_prev = 1'b0;
   logic [8:0]  txq[4][$];
   logic [15:0] sbq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Uart model: drops ready with the strobe and stays busy a frame time
   always @(posedge clk) begin
      if (uart_tx_dv) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign uart_tx_dr = (busy_cnt == 0) && !uart_tx_dv;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic send(input int r, input logic [7:0] d, input logic l);
      txq[r].push_back({l, d});
   endtask

   task automatic expect_w(input int r, input logic [7:0] d);
      sbq.push_back({8'(r), d});
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < 4; i++) n += txq[i].size();
      return n;
   endfunction

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         if (txq[i].size() > 0) begin
            req_dv[i]        = 1'b1;
            req_d[i*8 +: 8]  = txq[i][0][7:0];
            req_last[i]      = txq[i][0][8];
         end else begin
            req_dv[i]        = 1'b0;
            req_d[i*8 +: 8]  = 8'h00;
            req_last[i]      = 1'b0;
         end
      end
   endtask

   task automatic drain(input int maxc);
      int k = 0;
      while ((sbq.size() != 0 || pending() != 0) && k < maxc) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      chk("drain", sbq.size(), 0);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_dv"}, uart_tx_dv, 0);
      chk({tag, "_d"}, uart_tx_d, 0);
      chk({tag, "_gv"}, grant_vld, 0);
      chk({tag, "_to"}, timeout, 0);
      chk({tag, "_gid"}, grant_id, 3);
   endtask

   // Requester driver: pop a word after each observed handshake
   initial begin
      logic [3:0] hsd;
      forever begin
         @(negedge clk);
         hsd = req_dv & req_dr;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++)
            if (hsd[i] && txq[i].size() > 0) void'(txq[i].pop_front());
         refresh();
      end
   end

   // Monitor: scoreboard, strobe latency, uart handshake rules
   initial begin
      logic [3:0]  hs;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (uart_tx_dv || hs_prev) chk("lat", uart_tx_dv, hs_prev);
         if (uart_tx_dv) begin
            chk("dv_busy", busy_cnt != 0, 0);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("word", {6'b0, grant_id, uart_tx_d}, e);
            end else begin
               chk("sb_underrun", sbq.size(), 1);
            end
            last_strobe_cyc = cyc;
         end
         if (busy_cnt != 0) chk("dr_busy", req_dr, 0);
         hs = req_dv & req_dr;
         hs_prev = |hs;
         for (int i = 0; i < 4; i++) if (hs[i]) hs_cnt[i]++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      int k;
      for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
      rst_n    = 1'b0;
      req_d    = '0;
      req_dv   = '0;
      req_last = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      reset_vals("rst");

      // Contention right after reset: requester 0 wins, then 3
      send(0, 8'hA0, 0); send(0, 8'hA1, 1);
      send(3, 8'hD0, 0); send(3, 8'hD1, 1);
      expect_w(0, 8'hA0); expect_w(0, 8'hA1);
      expect_w(3, 8'hD0); expect_w(3, 8'hD1);
      drain(500);

      // Fairness: all four streaming single-word packets
      @(negedge clk);
      for (int rep = 0; rep < 2; rep++)
         for (int r = 0; r < 4; r++) begin
            send(r, 8'(8'h80 + rep*4 + r), 1);
            expect_w(r, 8'(8'h80 + rep*4 + r));
         end
      drain(500);

      // Single requester, 3-word packet
      @(negedge clk);
      send(2, 8'h41, 0); send(2, 8'h42, 0); send(2, 8'h43, 1);
      expect_w(2, 8'h41); expect_w(2, 8'h42); expect_w(2, 8'h43);
      drain(500);
      @(negedge clk);
      chk("single_gv", grant_vld, 0);
      chk("single_gid", grant_id, 2);

      // Timeout: requester 1 stalls mid-packet, 2 waits its turn
      send(1, 8'h55, 0);
      send(2, 8'h66, 1);
      expect_w(1, 8'h55); expect_w(2, 8'h66);
      k = 0;
      while (!timeout && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("to_seen", timeout, 1);
      chk("to_dist", cyc - last_strobe_cyc, 50);
      chk("to_gv", grant_vld, 0);
      @(negedge clk);
      chk("to_pulse", timeout, 0);
      drain(500);
      @(negedge clk);
      chk("to_next_gid", grant_id, 2);

      // Reset after the 2nd of 4 words
      for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
      send(2, 8'h10, 0); send(2, 8'h11, 0);
      send(2, 8'h12, 0); send(2, 8'h13, 1);
      expect_w(2, 8'h10); expect_w(2, 8'h11);
      k = 0;
      while (hs_cnt[2] < 2 && k < 300) begin
         @(posedge clk);
         k++;
      end
      chk("rmid_hs", hs_cnt[2], 2);
      #2 rst_n = 1'b0;
      txq[2].delete();
      req_dv[2]   = 1'b0;
      req_last[2] = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      send(3, 8'h31, 1);
      send(1, 8'h21, 1);
      expect_w(1, 8'h21); expect_w(3, 8'h31);
      @(negedge clk);
      reset_vals("rmid");
      drain(500);

      // Slow uart: ready low for 40 clocks after each word
      busy_len = 40;
      @(negedge clk);
      send(0, 8'h70, 0); send(0, 8'h71, 0); send(0, 8'h72, 1);
      expect_w(0, 8'h70); expect_w(0, 8'h71); expect_w(0, 8'h72);
      drain(1000);
      @(negedge clk);
      chk("slow_gv", grant_vld, 0);
      chk("slow_gid", grant_id, 0);
      busy_len = 3;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
